// File: rtl/fb_pkg.sv
// Shared defaults and types for the ping-pong frame buffer.
// Swap-controller states and counter width live here so top and bench agree.
package fb_pkg;

  localparam int DW_DEF          = 16;
  localparam int AW_DEF          = 15;
  localparam int FRAME_WORDS_DEF = 19200;
  localparam int DROP_CNT_W      = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_t;

endpackage : fb_pkg

// File: rtl/dp_ram_core.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Deliberately free of bank/range logic and reset so it maps onto block RAM.
module dp_ram_core #(
  parameter int DW    = 16,
  parameter int DEPTH = 65536
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DW-1:0]            o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the array and its output register have no reset; a reset term would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule : dp_ram_core

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: capture writes one bank, display reads the other.
// Banks swap only at a display frame boundary once a complete frame exists.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int            DW          = DW_DEF,
  parameter int            AW          = AW_DEF,
  parameter int            FRAME_WORDS = FRAME_WORDS_DEF,
  parameter logic [DW-1:0] OOR_VALUE   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  wr_frame_done,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_frame_start,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  frame_pending,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [AW:0] FRAME_LIM = (AW+1)'(FRAME_WORDS);

  swap_state_t           r_state;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_frame_pending;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_rd_valid;
  logic                  r_rd_oor;
  logic                  r_rd_seen;

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_swap;
  logic                  w_rd_bank_nxt;
  logic [DW-1:0]         w_ram_q;

  assign w_wr_in_range = ({1'b0, wr_addr} < FRAME_LIM);
  assign w_rd_in_range = ({1'b0, rd_addr} < FRAME_LIM);

  // A swap happens at a display boundary when a frame is either waiting or completing right now.
  assign w_swap        = rd_frame_start && (wr_frame_done || (r_state == ST_PENDING));
  assign w_rd_bank_nxt = w_swap ? r_wr_bank : r_rd_bank;

  dp_ram_core #(
    .DW    (DW),
    .DEPTH (2 ** (AW + 1))
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (wr_en && w_wr_in_range),
    .i_wr_addr ({r_wr_bank, wr_addr}),
    .i_wr_data (wr_data),
    .i_rd_en   (rd_en && w_rd_in_range),
    .i_rd_addr ({w_rd_bank_nxt, rd_addr}),
    .o_rd_data (w_ram_q)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b1;
      r_frame_pending <= 1'b0;
      r_drop_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wr_frame_done && rd_frame_start) begin
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
          end else if (wr_frame_done) begin
            r_state         <= ST_PENDING;
            r_frame_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          // Completing a frame while one is still waiting overwrites the waiting bank.
          if (rd_frame_start) begin
            r_rd_bank       <= r_wr_bank;
            r_wr_bank       <= ~r_wr_bank;
            r_state         <= ST_IDLE;
            r_frame_pending <= 1'b0;
          end else if (wr_frame_done && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // r_rd_seen masks the unreset RAM output until the first read after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_oor  <= !w_rd_in_range;
        r_rd_seen <= 1'b1;
      end
    end
  end

  // NOTE: default assignment first so this combinational block cannot infer a latch.
  always_comb begin
    rd_data = '0;
    if (r_rd_seen) begin
      rd_data = r_rd_oor ? OOR_VALUE : w_ram_q;
    end
  end

  assign rd_valid      = r_rd_valid;
  assign wr_bank       = r_wr_bank;
  assign rd_bank       = r_rd_bank;
  assign frame_pending = r_frame_pending;
  assign drop_cnt      = r_drop_cnt;

  a_banks_distinct : assert property (@(posedge clk) disable iff (!rst_n) r_wr_bank != r_rd_bank);

endmodule : frame_buffer_pingpong

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for the ping-pong frame buffer: read vector table plus
// hand-written swap, drop, out-of-range and reset sequences.
module tb_frame_buffer_pingpong;

  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_frame_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_frame_start;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_bank;
  logic          rd_bank;
  logic          frame_pending;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  frame_buffer_pingpong #(
    .DW          (DW),
    .AW          (AW),
    .FRAME_WORDS (19200),
    .OOR_VALUE   (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_frame_done  (wr_frame_done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_frame_start (rd_frame_start),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .frame_pending  (frame_pending),
    .drop_cnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
  } rd_vec_t;

  rd_vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check({name, "_data"}, 32'(rd_data), 32'(exp));
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  task automatic pulse(input logic done, input logic start);
    wr_frame_done  = done;
    rd_frame_start = start;
    tick();
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  task automatic chk_state(input string name, input logic wb, input logic rb,
                           input logic pend, input logic [7:0] drops);
    check({name, "_wr_bank"}, 32'(wr_bank), 32'(wb));
    check({name, "_rd_bank"}, 32'(rd_bank), 32'(rb));
    check({name, "_pending"}, 32'(frame_pending), 32'(pend));
    check({name, "_drop_cnt"}, 32'(drop_cnt), 32'(drops));
  endtask

  initial begin
    // Reads against the frame 234..383 shown from bank 0.
    tbl[0] = '{en: 1'b1, addr: 15'd0,     exp_valid: 1'b1, exp_data: 16'd234};
    tbl[1] = '{en: 1'b1, addr: 15'd149,   exp_valid: 1'b1, exp_data: 16'd383};
    tbl[2] = '{en: 1'b0, addr: 15'd5,     exp_valid: 1'b0, exp_data: 16'd383};
    tbl[3] = '{en: 1'b1, addr: 15'd19200, exp_valid: 1'b1, exp_data: 16'd0};
    tbl[4] = '{en: 1'b0, addr: 15'd7,     exp_valid: 1'b0, exp_data: 16'd0};
    tbl[5] = '{en: 1'b1, addr: 15'd75,    exp_valid: 1'b1, exp_data: 16'd309};
    tbl[6] = '{en: 1'b1, addr: 15'd32767, exp_valid: 1'b1, exp_data: 16'd0};

    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_frame_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_frame_start = 1'b0;

    // 1. Reset values, during and after reset.
    #1 rst_n = 1'b0;
    tick(); tick();
    chk_state("rst_during", 1'b0, 1'b1, 1'b0, 8'd0);
    check("rst_during_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_during_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_state("rst_after", 1'b0, 1'b1, 1'b0, 8'd0);
    check("rst_after_rd_valid", 32'(rd_valid), 32'd0);

    // 2. Fill bank 0, complete, swap, read back.
    for (int i = 0; i < 150; i++) wr(AW'(i), DW'(234 + i));
    pulse(1'b1, 1'b0);
    chk_state("s2_done", 1'b0, 1'b1, 1'b1, 8'd0);
    pulse(1'b0, 1'b1);
    chk_state("s2_swap", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 150; i++) rd_chk("s2_rd", AW'(i), DW'(234 + i));
    tick();
    check("s2_valid_drop", 32'(rd_valid), 32'd0);

    // 3. Boundary with no completed frame: no swap, old frame repeats.
    pulse(1'b0, 1'b1);
    chk_state("s3_noswap", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) begin
      rd_en   = tbl[i].en;
      rd_addr = tbl[i].addr;
      tick();
      rd_en   = 1'b0;
      check($sformatf("s3_tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
      check($sformatf("s3_tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
    end

    // 4. Three completed frames before display: two drops, last frame shown.
    for (int f = 1; f <= 3; f++) begin
      for (int i = 0; i < 4; i++) wr(AW'(i), DW'(f * 16'h1000 + i));
      pulse(1'b1, 1'b0);
    end
    chk_state("s4_drops", 1'b1, 1'b0, 1'b1, 8'd2);
    pulse(1'b0, 1'b1);
    chk_state("s4_swap", 1'b0, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 4; i++) rd_chk("s4_rd", AW'(i), DW'(16'h3000 + i));

    // 5. Out-of-range write is ignored, out-of-range read returns 0.
    wr(15'd19200, 16'hDEAD);
    rd_chk("s5_oor", 15'd19200, 16'd0);

    // 6a. IDLE with done+start together, read in the same cycle sees the new bank.
    wr(15'd5, 16'h5A5A);
    rd_en = 1'b1; rd_addr = 15'd5;
    pulse(1'b1, 1'b1);
    rd_en = 1'b0;
    check("s6a_data", 32'(rd_data), 32'h5A5A);
    check("s6a_valid", 32'(rd_valid), 32'd1);
    chk_state("s6a", 1'b1, 1'b0, 1'b0, 8'd2);
    rd_chk("s6a_keep", 15'd0, 16'd234);

    // 6b. PENDING with done+start together: single swap, back to IDLE.
    wr(15'd0, 16'h7777);
    pulse(1'b1, 1'b0);
    chk_state("s6b_pend", 1'b1, 1'b0, 1'b1, 8'd2);
    rd_en = 1'b1; rd_addr = 15'd0;
    pulse(1'b1, 1'b1);
    rd_en = 1'b0;
    check("s6b_data", 32'(rd_data), 32'h7777);
    chk_state("s6b", 1'b0, 1'b1, 1'b0, 8'd2);

    // 6c. Asynchronous reset in the middle of a write burst.
    wr(15'd9, 16'h0001);
    rd_en = 1'b1; rd_addr = 15'd0; wr_en = 1'b1; wr_addr = 15'd10; wr_data = 16'h0002;
    tick();
    rd_en = 1'b0;
    check("s6c_pre_valid", 32'(rd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("s6c_async", 1'b0, 1'b1, 1'b0, 8'd0);
    check("s6c_async_valid", 32'(rd_valid), 32'd0);
    check("s6c_async_data", 32'(rd_data), 32'd0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse(1'b0, 1'b1);
    chk_state("s6c_noswap", 1'b0, 1'b1, 1'b0, 8'd0);

    // Drop counter saturates at 255.
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 260; i++) pulse(1'b1, 1'b0);
    chk_state("sat", 1'b0, 1'b1, 1'b1, 8'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_frame_buffer_pingpong
